pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush sequencer for the 5-stage pipeline (FE, DE, EX, MEM, WB). It merges four stall and flush sources into a single consistent set of pipeline-register enables and clears:
- load-use hazards;
- taken branches and jumps resolved in EX;
- multi-cycle mul/div operations in EX;
- data-memory wait states in MEM.

It also tracks wait-state duration, flags a memory timeout, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- DM_TIMEOUT, 64: number of consecutive data-memory wait cycles after which dm_timeout is set (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs1_de, rs2_de  in  5 each  source registers of the instruction in DE.
- rs1_used_de, rs2_used_de  in  1 each  instruction in DE actually reads rs1 / rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- DMRd_ex  in  1  instruction in EX is a load.
- br_taken_ex  in  1  branch/jump in EX resolved taken (PC redirect this cycle).
- md_op_ex  in  1  multi-cycle mul/div occupies EX.
- md_done  in  1  mul/div result valid this cycle.
- dm_req_mem  in  1  instruction in MEM accesses data memory.
- dm_ack  in  1  data memory completes the access this cycle.
- pc_fe  out  1  PC write enable.
- en_de, en_ex, en_mem  out  1 each  load enables of the FE/DE, DE/EX and EX/MEM registers.
- clr_de, clr_ex, clr_mem, clr_wb  out  1 each  synchronous bubble insert into the FE/DE, DE/EX, EX/MEM and MEM/WB registers.
- dm_timeout  out  1  sticky memory-timeout flag.
- state_o  out  2  current state: 0 RUN, 1 DM_WAIT, 2 MD_WAIT.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
Conditions, evaluated every cycle:
- DMS = dm_req_mem & ~dm_ack.
- MDS = md_op_ex & ~md_done.
- LU = DMRd_ex & (rd_ex≠0) & ((rs1_used_de & rs1_de==rd_ex) | (rs2_used_de & rs2_de==rd_ex)).

Outputs resolve in strict priority order. The first matching case applies.
1. DMS: pc_fe=en_de=en_ex=en_mem=0, clr_wb=1, all other clears 0.
2. MDS: pc_fe=en_de=en_ex=0, en_mem=1, clr_mem=1.
3. br_taken_ex: all enables 1, clr_de=clr_ex=1. A branch frozen by case 1 or 2 keeps br_taken_ex high, so its flush is applied on the first unstalled cycle.
4. LU: pc_fe=en_de=0, en_ex=en_mem=1, clr_ex=1. This is exactly one bubble, because the load leaves EX at the next edge.
5. Otherwise: all enables 1, all clears 0.

State machine:
- The next state is computed from the same conditions: DM_WAIT if DMS, else MD_WAIT if MDS, else RUN.
- Transitions DM_WAIT↔MD_WAIT are legal directly, e.g. a memory stall can end while mul/div is still busy.

Memory wait counter:
- Counts consecutive DMS cycles and clears to 0 on any cycle without DMS.
- dm_timeout is set at the edge that ends the DM_TIMEOUT-th consecutive DMS cycle.
- dm_timeout is cleared only by reset. It does not release the stall.

Performance counters:
- stall_cnt increments on every cycle with pc_fe=0.
- flush_cnt increments on every cycle where case 3 applies.
- Both saturate at 2^CNT_W−1.

## Timing
- All enable and clear outputs are combinational from current inputs. A hazard is answered in the same cycle it appears, so the pipeline registers act on it at the next edge.
- state_o, the wait counter, dm_timeout and the performance counters are registered.
- While rst_n=0, asynchronously and independent of clk:
  - all enables are 0 and all clears are 1;
  - state_o=0, dm_timeout=0, stall_cnt=flush_cnt=0, wait counter=0.
- After deassertion, operation starts on the first rising edge.
- Reset asserted mid-stall aborts the stall immediately. No memory of the pending condition is kept.
- Simultaneous events:
  - DMS+MDS: DMS wins; MD_WAIT follows if MDS persists after dm_ack.
  - DMS+LU: case 1 applies. The load-use bubble is inserted after release because LU still holds.
  - br_taken_ex+LU cannot legally coexist. If both are seen, case 3 applies.
- dm_ack in the same cycle as dm_req_mem means no stall and a 0-cycle latency.

## Test plan
- Load-use: DMRd_ex=1, rd_ex=5, rs1_de=5, rs1_used_de=1 for one cycle → pc_fe=0, en_de=0, clr_ex=1 that cycle; stall_cnt=1 after the edge; rd_ex=0 with the same operands gives no stall.
- Branch flush: br_taken_ex=1 for one cycle → clr_de=clr_ex=1, pc_fe=1, flush_cnt=1; branch held during a 3-cycle MDS → no clears for 3 cycles, then flush on the 4th cycle.
- Mul/div: md_op_ex=1 with md_done after 4 cycles → state_o=2 for 4 edges, clr_mem=1, en_mem=1 during MDS, stall_cnt=4.
- Memory wait: dm_req_mem=1, dm_ack after 3 cycles while MDS is active → state_o sequence 1,1,1,2, clr_wb=1 only in DM_WAIT.
- Timeout: DM_TIMEOUT=4, dm_ack held low → dm_timeout=1 after the 4th edge and stays 1 after dm_ack; stall persists until dm_ack.
- Reset mid-DM_WAIT: rst_n=0 asynchronously → all clears 1, enables 0, counters and state 0 without waiting for a clk edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch,
// mul/div and data-memory hazards into pipeline-register enables and clears.
module pipe_ctrl #(
    parameter int DM_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             rs1_used_de,
    input  logic             rs2_used_de,
    input  logic [4:0]       rd_ex,
    input  logic             DMRd_ex,
    input  logic             br_taken_ex,
    input  logic             md_op_ex,
    input  logic             md_done,
    input  logic             dm_req_mem,
    input  logic             dm_ack,
    output logic             pc_fe,
    output logic             en_de,
    output logic             en_ex,
    output logic             en_mem,
    output logic             clr_de,
    output logic             clr_ex,
    output logic             clr_mem,
    output logic             clr_wb,
    output logic             dm_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WC_W    = $clog2(DM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(DM_TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(DM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DM_WAIT = 2'd1,
        ST_MD_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic dms_s, mds_s, lu_s, flush_s;
    logic pc_fe_s, en_de_s, en_ex_s, en_mem_s;
    logic clr_de_s, clr_ex_s, clr_mem_s, clr_wb_s;

    assign dms_s = dm_req_mem & ~dm_ack;
    assign mds_s = md_op_ex & ~md_done;
    assign lu_s  = DMRd_ex & (rd_ex != 5'd0) &
                   ((rs1_used_de & (rs1_de == rd_ex)) | (rs2_used_de & (rs2_de == rd_ex)));

    // Priority resolution of hazards into enables/clears, plus next state.
    always_comb begin
        pc_fe_s   = 1'b1;
        en_de_s   = 1'b1;
        en_ex_s   = 1'b1;
        en_mem_s  = 1'b1;
        clr_de_s  = 1'b0;
        clr_ex_s  = 1'b0;
        clr_mem_s = 1'b0;
        clr_wb_s  = 1'b0;
        flush_s   = 1'b0;
        state_d   = ST_RUN;
        if (dms_s) begin
            pc_fe_s  = 1'b0;
            en_de_s  = 1'b0;
            en_ex_s  = 1'b0;
            en_mem_s = 1'b0;
            clr_wb_s = 1'b1;
            state_d  = ST_DM_WAIT;
        end else if (mds_s) begin
            pc_fe_s   = 1'b0;
            en_de_s   = 1'b0;
            en_ex_s   = 1'b0;
            clr_mem_s = 1'b1;
            state_d   = ST_MD_WAIT;
        end else if (br_taken_ex) begin
            // A frozen branch lands here on its first unstalled cycle.
            clr_de_s = 1'b1;
            clr_ex_s = 1'b1;
            flush_s  = 1'b1;
        end else if (lu_s) begin
            pc_fe_s  = 1'b0;
            en_de_s  = 1'b0;
            clr_ex_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
    end

    // Wait counter, sticky timeout and saturating performance counters.
    always_comb begin
        wait_d    = wait_q;
        timeout_d = timeout_q | (dms_s & (wait_q == WC_LAST));
        stall_d   = stall_q;
        flush_d   = flush_q;
        if (!dms_s) begin
            wait_d = {WC_W{1'b0}};
        end else if (wait_q != WC_MAX) begin
            wait_d = wait_q + WC_W'(1);
        end else begin
            wait_d = wait_q;
        end
        if (!pc_fe_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
        if (flush_s && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_W'(1);
        end else begin
            flush_d = flush_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            wait_q    <= {WC_W{1'b0}};
            timeout_q <= 1'b0;
            stall_q   <= {CNT_W{1'b0}};
            flush_q   <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    // Reset forces a freeze-and-flush on the pipeline without waiting for clk.
    assign pc_fe   = rst_n & pc_fe_s;
    assign en_de   = rst_n & en_de_s;
    assign en_ex   = rst_n & en_ex_s;
    assign en_mem  = rst_n & en_mem_s;
    assign clr_de  = ~rst_n | clr_de_s;
    assign clr_ex  = ~rst_n | clr_ex_s;
    assign clr_mem = ~rst_n | clr_mem_s;
    assign clr_wb  = ~rst_n | clr_wb_s;

    assign dm_timeout = timeout_q;
    assign state_o    = state_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with a small reference model.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int DMT   = 4;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1_de = 5'd0, rs2_de = 5'd0, rd_ex = 5'd0;
    logic rs1_used_de = 1'b0, rs2_used_de = 1'b0, DMRd_ex = 1'b0;
    logic br_taken_ex = 1'b0, md_op_ex = 1'b0, md_done = 1'b0;
    logic dm_req_mem = 1'b0, dm_ack = 1'b0;
    logic pc_fe, en_de, en_ex, en_mem, clr_de, clr_ex, clr_mem, clr_wb, dm_timeout;
    logic [1:0] state_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.DM_TIMEOUT(DMT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_de(rs1_de), .rs2_de(rs2_de),
        .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de),
        .rd_ex(rd_ex), .DMRd_ex(DMRd_ex), .br_taken_ex(br_taken_ex),
        .md_op_ex(md_op_ex), .md_done(md_done),
        .dm_req_mem(dm_req_mem), .dm_ack(dm_ack),
        .pc_fe(pc_fe), .en_de(en_de), .en_ex(en_ex), .en_mem(en_mem),
        .clr_de(clr_de), .clr_ex(clr_ex), .clr_mem(clr_mem), .clr_wb(clr_wb),
        .dm_timeout(dm_timeout), .state_o(state_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ctl bit order: pc_fe en_de en_ex en_mem clr_de clr_ex clr_mem clr_wb
    typedef struct {
        logic [7:0]       ctl;
        logic [1:0]       st;
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    int               m_wait = 0;
    logic             m_to = 1'b0;
    logic [1:0]       m_st = 2'd0;
    logic [CNT_W-1:0] m_sc = '0;
    logic [CNT_W-1:0] m_fc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_to   = 1'b0;
        m_st   = 2'd0;
        m_sc   = '0;
        m_fc   = '0;
    endtask

    // One pipeline cycle: drive at negedge, check combinational outputs
    // mid-low-phase, check registered outputs just after the rising edge.
    task automatic cyc(input string tag,
                       input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic br,
                       input logic md, input logic mdd,
                       input logic req, input logic ack);
        exp_t e;
        exp_t g;
        logic dms, mds, lu;
        @(negedge clk);
        rs1_de = r1; rs1_used_de = u1; rs2_de = r2; rs2_used_de = u2;
        rd_ex = rd; DMRd_ex = ld; br_taken_ex = br;
        md_op_ex = md; md_done = mdd; dm_req_mem = req; dm_ack = ack;

        dms = req & ~ack;
        mds = md & ~mdd;
        lu  = ld & (rd != 5'd0) & ((u1 & (r1 == rd)) | (u2 & (r2 == rd)));
        if (dms)      e.ctl = 8'b0000_0001;
        else if (mds) e.ctl = 8'b0001_0010;
        else if (br)  e.ctl = 8'b1111_1100;
        else if (lu)  e.ctl = 8'b0011_0100;
        else          e.ctl = 8'b1111_0000;

        m_st = dms ? 2'd1 : (mds ? 2'd2 : 2'd0);
        m_wait = dms ? m_wait + 1 : 0;
        if (m_wait >= DMT) m_to = 1'b1;
        if (!e.ctl[7] && m_sc != CMAX) m_sc = m_sc + 1'b1;
        if (!dms && !mds && br && m_fc != CMAX) m_fc = m_fc + 1'b1;
        e.st = m_st; e.to = m_to; e.sc = m_sc; e.fc = m_fc;
        sb.push_back(e);

        #2;
        chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            g = sb.pop_front();
            chk({tag, ".ctl"}, 32'({pc_fe, en_de, en_ex, en_mem, clr_de, clr_ex, clr_mem, clr_wb}), 32'(g.ctl));
            @(posedge clk);
            #1;
            chk({tag, ".state"}, 32'(state_o), 32'(g.st));
            chk({tag, ".timeout"}, 32'(dm_timeout), 32'(g.to));
            chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(g.sc));
            chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(g.fc));
        end
    endtask

    task automatic idle(input string tag);
        cyc(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ctl"}, 32'({pc_fe, en_de, en_ex, en_mem, clr_de, clr_ex, clr_mem, clr_wb}), 32'h0F);
        chk({tag, ".state"}, 32'(state_o), 32'd0);
        chk({tag, ".timeout"}, 32'(dm_timeout), 32'd0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'd0);
    endtask

    initial begin
        #3;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle("idle0");

        // Load-use on rs1, then rd=0 gives no stall, then rs2 match.
        cyc("lu_rs1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall_is_1", 32'(stall_cnt), 32'd1);
        cyc("lu_rd0", 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rd0_no_stall", 32'(stall_cnt), 32'd1);
        cyc("lu_unused", 5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs2", 5'd1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single branch flush.
        cyc("br1", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br1_flush_is_1", 32'(flush_cnt), 32'd1);

        // Branch held across a 3-cycle mul/div stall, flushed on the 4th.
        for (int i = 0; i < 3; i++)
            cyc("br_md", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("br_md_rel", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_md_flush_is_2", 32'(flush_cnt), 32'd2);

        // Mul/div busy 4 cycles then done.
        for (int i = 0; i < 4; i++)
            cyc("md", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("md_done", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Memory wait 3 cycles with mul/div busy, then MD_WAIT, then done.
        for (int i = 0; i < 3; i++)
            cyc("dm_md", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("dm_ack_md", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("dm_to_md_state", 32'(state_o), 32'd2);
        cyc("md_fin", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Memory stall overlapping load-use: bubble after release.
        for (int i = 0; i < 2; i++)
            cyc("dm_lu", 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("dm_lu_rel", 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("br_lu", 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dm_zero_lat", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Timeout: sets after the 4th consecutive wait edge, sticky past ack.
        for (int i = 0; i < 5; i++) begin
            cyc("to_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 2) chk("to_not_yet", 32'(dm_timeout), 32'd0);
            if (i == 3) chk("to_set", 32'(dm_timeout), 32'd1);
        end
        cyc("to_ack", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("to_after");
        chk("to_sticky", 32'(dm_timeout), 32'd1);

        // Flush counter saturation.
        for (int i = 0; i < 16; i++)
            cyc("br_sat", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_sat", 32'(flush_cnt), 32'(CMAX));
        chk("stall_sat", 32'(stall_cnt), 32'(CMAX));

        // Asynchronous reset in the middle of DM_WAIT.
        for (int i = 0; i < 2; i++)
            cyc("dm_pre_rst", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        model_reset();
        @(negedge clk);
        dm_req_mem = 1'b0;
        rst_n = 1'b1;
        idle("post_rst");
        cyc("post_rst_lu", 5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
